usbh_report_arbiter: RTL and testbench



---
 rtl/usbh_report_arbiter_pkg.sv | 29 ++
 rtl/usbh_report_slot.sv | 71 +++++++
 rtl/usbh_report_arbiter.sv | 159 +++++++++++++++
 tb/tb_usbh_report_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/usbh_report_arbiter_pkg.sv
// usbh_report_arbiter_pkg
// Shared types and constants for the two-player USB report arbiter.
//   arb_state_t          : pass sequencer state (IDLE, ISSUE, WAIT, CAPTURE)
//   c_slot_bits          : width of a slot index (two slots)
//   c_timeout_cycles     : silence timeout in clocks for the default clock/timeout
//   c_timeout_bits       : counter width able to hold c_timeout_cycles
//   calc_timeout_cycles  : timeout in clocks for a given clock rate and timeout
package usbh_report_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } arb_state_t;

  localparam int c_slot_bits      = 1;
  localparam int c_def_clk_hz     = 48000000;
  localparam int c_def_timeout_ms = 100;

  localparam int c_timeout_cycles = c_def_clk_hz / 1000 * c_def_timeout_ms;
  localparam int c_timeout_bits   = $clog2(c_timeout_cycles + 1);

  // Divide before multiplying so 48 MHz x 100 ms stays inside 32 bits.
  function automatic int calc_timeout_cycles(input int clk_hz, input int timeout_ms);
    return clk_hz / 1000 * timeout_ms;
  endfunction

endpackage

// File: rtl/usbh_report_slot.sv
// usbh_report_slot
// Per-player report holding slot: latest report buffer, pending flag,
// silence timeout counter and connected flag.
// Ports:
//   i_clk, i_rstn    : clock, asynchronous active-low reset
//   i_report         : report from the host core
//   i_report_valid   : one-cycle strobe qualifying i_report
//   i_take           : arbiter copies the buffer this cycle (clears pending)
//   o_buffer         : latest report (zero while disconnected)
//   o_pending        : a report arrived that has not been decoded yet
//   o_connected      : a report arrived within the timeout
//   o_expire         : one-cycle pulse on the cycle the timeout is reached
module usbh_report_slot
  import usbh_report_arbiter_pkg::*;
#(
  parameter int c_report_bits    = 160,
  parameter int c_timeout_cycles = usbh_report_arbiter_pkg::c_timeout_cycles,
  parameter int c_timeout_bits   = usbh_report_arbiter_pkg::c_timeout_bits
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [c_report_bits-1:0] i_report,
  input  logic                     i_report_valid,
  input  logic                     i_take,
  output logic [c_report_bits-1:0] o_buffer,
  output logic                     o_pending,
  output logic                     o_connected,
  output logic                     o_expire
);

  localparam logic [c_timeout_bits-1:0] c_term    = c_timeout_bits'(c_timeout_cycles);
  localparam logic [c_timeout_bits-1:0] c_term_m1 = c_timeout_bits'(c_timeout_cycles - 1);

  logic [c_timeout_bits-1:0] tmo_cnt;

  // A fresh report on the would-be expiry cycle keeps the slot alive.
  assign o_expire = !i_report_valid && (tmo_cnt == c_term_m1);

  // The counter resets to terminal count so a slot is disconnected until its
  // first report.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      tmo_cnt     <= c_term;
      o_buffer    <= '0;
      o_connected <= 1'b0;
    end else if (i_report_valid) begin
      tmo_cnt     <= '0;
      o_buffer    <= i_report;
      o_connected <= 1'b1;
    end else if (tmo_cnt != c_term) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (o_expire) begin
        o_connected <= 1'b0;
        o_buffer    <= '0;
      end
    end
  end

  // Set beats clear: a report landing on the copy cycle stays pending so the
  // new data gets its own pass.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_pending <= 1'b0;
    end else if (i_report_valid) begin
      o_pending <= 1'b1;
    end else if (i_take) begin
      o_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/usbh_report_arbiter.sv
// usbh_report_arbiter
// Time-shares one report decoder between two USB host report streams and
// demultiplexes the decoded NES buttons into per-player registers.
// Ports:
//   i_clk, i_rstn               : USB core clock, asynchronous active-low reset
//   i_report0/1, *_valid        : latest report and strobe from host 0/1
//   o_dec_report                : report presented to the decoder, held per pass
//   o_dec_report_valid          : one-cycle decoder start strobe
//   i_dec_btn                   : decoder button output
//   o_btn0, o_btn1              : player 0/1 NES buttons
//   o_connected                 : bit N set while slot N is reporting
module usbh_report_arbiter
  import usbh_report_arbiter_pkg::*;
#(
  parameter int c_clk_hz      = 48000000,
  parameter int c_report_bits = 160,
  parameter int c_dec_latency = 2,
  parameter int c_timeout_ms  = 100
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [c_report_bits-1:0] i_report0,
  input  logic                     i_report0_valid,
  input  logic [c_report_bits-1:0] i_report1,
  input  logic                     i_report1_valid,
  output logic [c_report_bits-1:0] o_dec_report,
  output logic                     o_dec_report_valid,
  input  logic [7:0]               i_dec_btn,
  output logic [7:0]               o_btn0,
  output logic [7:0]               o_btn1,
  output logic [1:0]               o_connected
);

  localparam int c_tmo_cycles = calc_timeout_cycles(c_clk_hz, c_timeout_ms);
  localparam int c_tmo_bits   = $clog2(c_tmo_cycles + 1);

  // WAIT spans c_dec_latency-1 cycles; the counter marks its last cycle.
  localparam int c_wait_bits = (c_dec_latency > 2) ? $clog2(c_dec_latency) : 1;
  localparam logic [c_wait_bits-1:0] c_wait_last = c_wait_bits'(c_dec_latency - 2);

  arb_state_t state, state_nxt;
  logic [c_wait_bits-1:0] wait_cnt;
  logic [c_slot_bits-1:0] sel_q, sel_nxt, rr_ptr;

  logic [c_report_bits-1:0] buf0, buf1;
  logic pend0, pend1, conn0, conn1, expire0, expire1, take0, take1;

  usbh_report_slot #(
    .c_report_bits   (c_report_bits),
    .c_timeout_cycles(c_tmo_cycles),
    .c_timeout_bits  (c_tmo_bits)
  ) u_slot0 (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_report      (i_report0),
    .i_report_valid(i_report0_valid),
    .i_take        (take0),
    .o_buffer      (buf0),
    .o_pending     (pend0),
    .o_connected   (conn0),
    .o_expire      (expire0)
  );

  usbh_report_slot #(
    .c_report_bits   (c_report_bits),
    .c_timeout_cycles(c_tmo_cycles),
    .c_timeout_bits  (c_tmo_bits)
  ) u_slot1 (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_report      (i_report1),
    .i_report_valid(i_report1_valid),
    .i_take        (take1),
    .o_buffer      (buf1),
    .o_pending     (pend1),
    .o_connected   (conn1),
    .o_expire      (expire1)
  );

  assign o_connected = {conn1, conn0};

  // State register; reset aborts any pass in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Passes run back to back; with nothing pending, the slot at the pointer gets
  // a refresh pass so decoder autofire keeps toggling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == c_wait_last) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fresh reports take priority; ties and refreshes follow the round-robin pointer.
  always_comb begin
    sel_nxt = rr_ptr;
    if (pend0 && !pend1) begin
      sel_nxt = 1'b0;
    end else if (pend1 && !pend0) begin
      sel_nxt = 1'b1;
    end
    o_dec_report_valid = (state == ISSUE);
    take0 = (state == IDLE) && (sel_nxt == 1'b0);
    take1 = (state == IDLE) && (sel_nxt == 1'b1);
  end

  // o_dec_report loads only on the IDLE exit edge because the decoder's
  // autofire path reads it combinationally for the whole pass.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel_q        <= '0;
      rr_ptr       <= '0;
      o_dec_report <= '0;
      wait_cnt     <= '0;
    end else begin
      if (state == IDLE) begin
        sel_q        <= sel_nxt;
        rr_ptr       <= ~sel_nxt;
        o_dec_report <= (sel_nxt == 1'b1) ? buf1 : buf0;
      end
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Expiry wins over a capture landing on the same edge; disconnected slots
  // always capture zero.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_btn0 <= '0;
      o_btn1 <= '0;
    end else begin
      if (expire0) begin
        o_btn0 <= '0;
      end else if (state == CAPTURE && sel_q == 1'b0) begin
        o_btn0 <= conn0 ? i_dec_btn : 8'h00;
      end
      if (expire1) begin
        o_btn1 <= '0;
      end else if (state == CAPTURE && sel_q == 1'b1) begin
        o_btn1 <= conn1 ? i_dec_btn : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_usbh_report_arbiter.sv
// tb_usbh_report_arbiter
// Directed bench for usbh_report_arbiter with a two-stage decoder stand-in.
// Runs with a 1 MHz clock and 1 ms timeout so slot expiry takes 1000 cycles.
module tb_usbh_report_arbiter;

  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b0;
  logic [159:0] i_report0 = '0;
  logic         i_report0_valid = 1'b0;
  logic [159:0] i_report1 = '0;
  logic         i_report1_valid = 1'b0;
  logic [159:0] o_dec_report;
  logic         o_dec_report_valid;
  logic [7:0]   i_dec_btn;
  logic [7:0]   o_btn0, o_btn1;
  logic [1:0]   o_connected;

  int checkCount = 0;
  int errCount = 0;

  logic [159:0] rep_a, rep_b, rep_c, rep_d, rep_e;

  usbh_report_arbiter #(
    .c_clk_hz     (1000000),
    .c_report_bits(160),
    .c_dec_latency(2),
    .c_timeout_ms (1)
  ) dut (
    .i_clk             (i_clk),
    .i_rstn            (i_rstn),
    .i_report0         (i_report0),
    .i_report0_valid   (i_report0_valid),
    .i_report1         (i_report1),
    .i_report1_valid   (i_report1_valid),
    .o_dec_report      (o_dec_report),
    .o_dec_report_valid(o_dec_report_valid),
    .i_dec_btn         (i_dec_btn),
    .o_btn0            (o_btn0),
    .o_btn1            (o_btn1),
    .o_connected       (o_connected)
  );

  always #5 i_clk = ~i_clk;

  // Decoder stand-in: maps report bits to NES buttons, output stable two
  // cycles after the report-valid strobe.
  function automatic logic [7:0] nes_of(input logic [159:0] r);
    return {r[24], r[23], r[22], r[21], r[20], r[30], r[29], r[28]};
  endfunction

  logic [7:0] dec_stage = 8'h00;
  logic [7:0] dec_out = 8'h00;
  assign i_dec_btn = dec_out;

  always @(posedge i_clk) begin
    if (o_dec_report_valid) dec_stage <= nes_of(o_dec_report);
    dec_out <= dec_stage;
  end

  task automatic checkOutput(input string tag, input logic [159:0] actual, input logic [159:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [159:0] r0, input logic v1, input logic [159:0] r1);
    i_report0_valid = v0;
    i_report0       = r0;
    i_report1_valid = v1;
    i_report1       = r1;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  // Advance to the next ISSUE cycle, bounded.
  task automatic syncIssue();
    int n;
    n = 0;
    step(1);
    while (!o_dec_report_valid && n < 10) begin
      step(1);
      n++;
    end
    checkOutput("sync_issue", 160'(o_dec_report_valid), 160'(1));
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rep_a = 160'(1) << 28;
    rep_b = 160'(1) << 29;
    rep_c = 160'(1) << 20;
    rep_d = 160'(1) << 30;
    rep_e = (160'(1) << 28) | (160'(1) << 29);

    // Reset values
    step(2);
    checkOutput("rst_btn0", 160'(o_btn0), 160'(0));
    checkOutput("rst_btn1", 160'(o_btn1), 160'(0));
    checkOutput("rst_conn", 160'(o_connected), 160'(0));
    checkOutput("rst_valid", 160'(o_dec_report_valid), 160'(0));
    checkOutput("rst_report", o_dec_report, 160'(0));
    i_rstn = 1'b1;

    // Single report on slot 0, strobed in CAPTURE so the next IDLE serves it
    syncIssue();
    step(2);
    applyStimulus(1'b1, rep_a, 1'b0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    step(1);
    checkOutput("t1_valid", 160'(o_dec_report_valid), 160'(1));
    checkOutput("t1_report", o_dec_report, rep_a);
    step(3);
    checkOutput("t1_btn0", 160'(o_btn0), 160'(8'h01));
    checkOutput("t1_btn1", 160'(o_btn1), 160'(0));
    checkOutput("t1_conn", 160'(o_connected), 160'(2'b01));

    // Both slots report together while the pointer is at slot 0
    step(3);
    applyStimulus(1'b1, rep_b, 1'b1, rep_c);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    step(1);
    checkOutput("t2_first_report", o_dec_report, rep_b);
    step(3);
    checkOutput("t2_btn0", 160'(o_btn0), 160'(8'h02));
    step(1);
    checkOutput("t2_second_report", o_dec_report, rep_c);
    step(3);
    checkOutput("t2_btn1", 160'(o_btn1), 160'(8'h08));
    checkOutput("t2_conn", 160'(o_connected), 160'(2'b11));

    // Refresh passes alternate 0,1,0,1 with the report held over each pass
    for (int k = 0; k < 4; k++) begin
      logic [159:0] exp_rep;
      exp_rep = (k % 2 == 0) ? rep_b : rep_c;
      step(1);
      checkOutput($sformatf("t3_issue_valid%0d", k), 160'(o_dec_report_valid), 160'(1));
      checkOutput($sformatf("t3_issue_report%0d", k), o_dec_report, exp_rep);
      step(1);
      checkOutput($sformatf("t3_wait_valid%0d", k), 160'(o_dec_report_valid), 160'(0));
      checkOutput($sformatf("t3_wait_report%0d", k), o_dec_report, exp_rep);
      step(1);
      checkOutput($sformatf("t3_capt_report%0d", k), o_dec_report, exp_rep);
      step(1);
    end
    checkOutput("t3_btn0", 160'(o_btn0), 160'(8'h02));
    checkOutput("t3_btn1", 160'(o_btn1), 160'(8'h08));

    // Buffer write mid-pass leaves o_dec_report alone; fresh data preempts the pointer
    step(2);
    applyStimulus(1'b1, rep_d, 1'b0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t3b_held_report", o_dec_report, rep_b);
    step(1);
    checkOutput("t3b_btn0_old", 160'(o_btn0), 160'(8'h02));
    step(1);
    checkOutput("t3b_fresh_report", o_dec_report, rep_d);
    step(3);
    checkOutput("t3b_btn0_new", 160'(o_btn0), 160'(8'h04));

    // Slot 0 report on the IDLE edge that copies slot 0
    step(4);
    applyStimulus(1'b1, rep_e, 1'b0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t5_old_report", o_dec_report, rep_d);
    step(3);
    checkOutput("t5_btn0_old", 160'(o_btn0), 160'(8'h04));
    step(1);
    checkOutput("t5_new_report", o_dec_report, rep_e);
    step(3);
    checkOutput("t5_btn0_new", 160'(o_btn0), 160'(8'h03));

    // Timeout: valid on the expiry cycle keeps the slot, silence drops it
    applyStimulus(1'b1, rep_a, 1'b0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    step(999);
    checkOutput("t4_conn_before", 160'(o_connected[0]), 160'(1));
    applyStimulus(1'b1, rep_a, 1'b0, '0);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("t4_conn_rescued", 160'(o_connected[0]), 160'(1));
    step(999);
    checkOutput("t4_conn_last", 160'(o_connected[0]), 160'(1));
    step(1);
    checkOutput("t4_conn_expired", 160'(o_connected), 160'(2'b00));
    checkOutput("t4_btn0_cleared", 160'(o_btn0), 160'(0));
    step(8);
    checkOutput("t4_btn0_forced", 160'(o_btn0), 160'(0));
    checkOutput("t4_btn1_forced", 160'(o_btn1), 160'(0));

    // Reset asserted during WAIT
    applyStimulus(1'b1, rep_a, 1'b1, rep_c);
    step(1);
    applyStimulus(1'b0, '0, 1'b0, '0);
    step(12);
    checkOutput("t6_btn0_pre", 160'(o_btn0), 160'(8'h01));
    checkOutput("t6_btn1_pre", 160'(o_btn1), 160'(8'h08));
    syncIssue();
    step(1);
    #2;
    i_rstn = 1'b0;
    #1;
    checkOutput("t6_async_btn0", 160'(o_btn0), 160'(0));
    checkOutput("t6_async_btn1", 160'(o_btn1), 160'(0));
    checkOutput("t6_async_conn", 160'(o_connected), 160'(0));
    checkOutput("t6_async_report", o_dec_report, 160'(0));
    checkOutput("t6_async_valid", 160'(o_dec_report_valid), 160'(0));
    step(2);
    i_rstn = 1'b1;
    checkOutput("t6_rel_conn", 160'(o_connected), 160'(0));
    step(8);
    checkOutput("t6_post_btn0", 160'(o_btn0), 160'(0));
    checkOutput("t6_post_btn1", 160'(o_btn1), 160'(0));
    checkOutput("t6_post_conn", 160'(o_connected), 160'(0));

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
